// File: rtl/booth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_pkg : shared state, select codes and per-state control decode
// Rev 1.0
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SHR   = 2'b10;
  localparam logic [1:0] SEL_CLR   = 2'b11;

  localparam logic [1:0] QSEL_HOLD = 2'b00;
  localparam logic [1:0] QSEL_SHR  = 2'b10;
  localparam logic [1:0] QSEL_LOAD = 2'b11;

  typedef struct packed {
    logic       m_en;
    logic [1:0] a_sel;
    logic [1:0] q_sel;
    logic       alu_sub;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore decode; registered by the FSM against the state being entered.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c       = '0;
    c.busy  = (s != IDLE);
    c.a_sel = SEL_HOLD;
    c.q_sel = QSEL_HOLD;
    case (s)
      LOAD: begin
        c.m_en  = 1'b1;
        c.a_sel = SEL_CLR;
        c.q_sel = QSEL_LOAD;
      end
      ADD:  c.a_sel = SEL_LOAD;
      SUB: begin
        c.a_sel   = SEL_LOAD;
        c.alu_sub = 1'b1;
      end
      SHIFT: begin
        c.a_sel = SEL_SHR;
        c.q_sel = QSEL_SHR;
      end
      DONE: c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iter_counter : CW-bit iteration counter with clear, increment, last flag
// Rev 1.0
// ---------------------------------------------------------------------------
module iter_counter #(
  parameter int CW   = 3,
  parameter int LAST = 7
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(LAST));

endmodule
`default_nettype wire

// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_seq_ctrl : radix-2 Booth multiplier sequencer (N test/op/shift rounds)
// Rev 1.0
// ---------------------------------------------------------------------------
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          q0,
  input  logic          q_1,
  output logic          m_en,
  output logic [1:0]    a_sel,
  output logic [1:0]    q_sel,
  output logic          alu_sub,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   iter_last;
  logic   iter_clr;
  logic   iter_inc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = TEST;
      TEST: begin
        case ({q0, q_1})
          2'b10:   state_d = SUB;
          2'b01:   state_d = ADD;
          default: state_d = SHIFT;
        endcase
      end
      ADD:   state_d = SHIFT;
      SUB:   state_d = SHIFT;
      SHIFT: state_d = iter_last ? DONE : TEST;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter reads 0 throughout LOAD and parks at N-1 after the final shift.
  assign iter_clr = (state_d == LOAD);
  assign iter_inc = (state_q == SHIFT) && !iter_last;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  iter_counter #(
    .CW   (CW),
    .LAST (N - 1)
  ) u_iter (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_i  (iter_clr),
    .inc_i  (iter_inc),
    .cnt_o  (iter),
    .last_o (iter_last)
  );

  assign m_en    = ctrl_q.m_en;
  assign a_sel   = ctrl_q.a_sel;
  assign q_sel   = ctrl_q.q_sel;
  assign alu_sub = ctrl_q.alu_sub;
  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_booth_seq_ctrl : directed bench with a behavioural A/Q/M datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_booth_seq_ctrl;

  localparam int N  = 8;
  localparam int CW = 3;

  logic          clk   = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic          q0, q_1;
  logic          m_en, alu_sub, busy, done;
  logic [1:0]    a_sel, q_sel;
  logic [CW-1:0] iter;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .q0(q0), .q_1(q_1),
    .m_en(m_en), .a_sel(a_sel), .q_sel(q_sel), .alu_sub(alu_sub),
    .busy(busy), .done(done), .iter(iter)
  );

  // Datapath registers steered by the controller's select codes.
  logic [8:0] acc   = '0;
  logic [7:0] mq    = '0;
  logic [7:0] mm    = '0;
  logic       qm1   = 1'b0;
  logic [7:0] bus_m = '0;
  logic [7:0] bus_q = '0;

  assign q0  = mq[0];
  assign q_1 = qm1;

  always @(posedge clk) begin
    if (m_en) mm <= bus_m;
    case (a_sel)
      2'b01:   acc <= alu_sub ? acc - {mm[7], mm} : acc + {mm[7], mm};
      2'b10:   acc <= {acc[8], acc[8:1]};
      2'b11:   acc <= '0;
      default: ;
    endcase
    case (q_sel)
      2'b10: begin mq <= {acc[0], mq[7:1]}; qm1 <= mq[0]; end
      2'b11: begin mq <= bus_q;             qm1 <= 1'b0;  end
      default: ;
    endcase
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Call at a negedge with the DUT idle; returns after the DONE cycle is sampled.
  task automatic do_mul(input logic [7:0] m, input logic [7:0] q,
                        output int cyc, output int shifts, output int ops,
                        output logic [7:0] seq, output logic [15:0] prod,
                        output logic [CW-1:0] it_done);
    bus_m = m;
    bus_q = q;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; shifts = 0; ops = 0; seq = '0; prod = '0; it_done = '0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (a_sel == 2'b10) shifts++;
      if (a_sel == 2'b01) begin ops++; seq = {seq[6:0], alu_sub}; end
      if (done) begin prod = {acc[7:0], mq}; it_done = iter; break; end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] prod;
    int          cyc;
    int          ops;
    logic [7:0]  seq;
  } vec_t;

  vec_t vecs[7];

  int            cyc, shifts, ops, n_done, done_at, done_at2, found;
  logic [7:0]    seq;
  logic [15:0]   prod;
  logic [CW-1:0] itd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {M, Q, product, DONE edge, ADD+SUB count, op sequence (1=SUB)}
    vecs[0] = '{8'h03, 8'h05, 16'h000F, 21, 4, 8'h0A};
    vecs[1] = '{8'h80, 8'h80, 16'h4000, 18, 1, 8'h01};
    vecs[2] = '{8'h7F, 8'h80, 16'hC080, 18, 1, 8'h01};
    vecs[3] = '{8'h5A, 8'h00, 16'h0000, 17, 0, 8'h00};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001, 18, 1, 8'h01};
    vecs[5] = '{8'h02, 8'h55, 16'h00AA, 25, 8, 8'hAA};
    vecs[6] = '{8'hFD, 8'h05, 16'hFFF1, 21, 4, 8'h0A};

    // Reset then idle
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({m_en, a_sel, q_sel, alu_sub, busy, done, iter}), 32'd0);
    end

    foreach (vecs[i]) begin
      do_mul(vecs[i].m, vecs[i].q, cyc, shifts, ops, seq, prod, itd);
      chk($sformatf("v%0d_product", i), 32'(prod), 32'(vecs[i].prod));
      chk($sformatf("v%0d_done_edge", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_ops", i), ops, vecs[i].ops);
      chk($sformatf("v%0d_op_seq", i), 32'(seq), 32'(vecs[i].seq));
      chk($sformatf("v%0d_shifts", i), shifts, N);
      chk($sformatf("v%0d_iter_at_done", i), 32'(itd), 32'(N - 1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_after_done", i), 32'({busy, done}), 32'd0);
      @(negedge clk);
    end

    // Extra start pulses while busy are ignored
    bus_m = 8'h03; bus_q = 8'h05;
    n_done = 0; done_at = -1;
    for (int c = 0; c <= 40; c++) begin
      start = (c == 0 || c == 5 || c == 12);
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (done_at < 0) begin done_at = c; prod = {acc[7:0], mq}; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored_start_done_count", n_done, 1);
    chk("ignored_start_done_edge", done_at, 21);
    chk("ignored_start_product", 32'(prod), 32'h000F);

    // start held high: IDLE gap, then a new LOAD
    bus_m = 8'h11; bus_q = 8'h00;
    n_done = 0; done_at = -1; done_at2 = -1; found = 0;
    start = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (c == 37) found = busy ? 1 : 0;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
        else if (done_at2 < 0) done_at2 = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_start_done_count", n_done, 2);
    chk("held_start_first_done", done_at, 17);
    chk("held_start_second_done", done_at2, 36);
    chk("held_start_idle_gap_busy", found, 0);
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) begin found = 1; break; end
    end
    chk("held_start_drain", found, 1);

    // Reset during ADD aborts the operation
    bus_m = 8'h03; bus_q = 8'h05;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = -1;
    for (int c = 1; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (a_sel == 2'b01 && !alu_sub) begin found = c; break; end
    end
    chk("abort_add_reached", found, 5);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_outputs_cleared", 32'({m_en, a_sel, q_sel, alu_sub, busy, done, iter}), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("abort_no_activity", n_done, 0);
    do_mul(8'h03, 8'h05, cyc, shifts, ops, seq, prod, itd);
    chk("abort_retry_product", 32'(prod), 32'h000F);
    chk("abort_retry_done_edge", cyc, 21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
